// File: rtl/versat_rr_arbiter.sv
// Registered round-robin arbiter for the Versat datapath.
// Grant bus is [N:1] one-hot, index 0 reserved for "no grant".
module versat_rr_arbiter #(
  parameter int BIN_W = 2,
  parameter bit LOCK  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2**BIN_W-1:1]  req,
  output logic [2**BIN_W-1:1]  grant,
  output logic                 grant_valid
);

  localparam int N = 2**BIN_W-1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [N:1]         grant_q, grant_d;
  logic [BIN_W-1:0]   ptr_q, ptr_d;
  logic               gv_q;

  logic [N:0]         req_x;
  logic [BIN_W:0]     cand;
  logic               win_found;
  logic [BIN_W-1:0]   win_idx;
  logic [N:1]         win_oh;
  logic               hold;

  assign req_x = {req, 1'b0};

  // Search from ptr+1 upward, wrapping N -> 1 explicitly, ending at ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int off = 1; off <= N; off++) begin
      cand = {1'b0, ptr_q} + (BIN_W+1)'(off);
      if (cand > (BIN_W+1)'(N))
        cand = cand - (BIN_W+1)'(N);
      if (!win_found && req_x[cand[BIN_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[BIN_W-1:0];
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 1; i <= N; i++)
      win_oh[i] = win_found && (win_idx == BIN_W'(i));
  end

  assign hold = LOCK && |(grant_q & req);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (en && win_found) begin
          state_d = BUSY;
          grant_d = win_oh;
          ptr_d   = win_idx;
        end
      end
      BUSY: begin
        if (!en) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (hold) begin
          grant_d = grant_q;
        end else if (win_found) begin
          grant_d = win_oh;
          ptr_d   = win_idx;
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gv_q    <= 1'b0;
      ptr_q   <= BIN_W'(N);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gv_q    <= |grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = gv_q;

endmodule

// File: tb/tb_versat_rr_arbiter.sv
// Bench for versat_rr_arbiter: LOCK=0 and LOCK=1 instances share stimulus
// and are compared each cycle against an index-level round-robin model.
module tb_versat_rr_arbiter;

  localparam int BIN_W = 2;
  localparam int N     = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [N:1] req;
  logic [N:1] g0, g1;
  logic       v0, v1;

  int checks = 0;
  int errors = 0;

  int m_ptr [2];
  int m_g   [2];

  always #5 clk = ~clk;

  versat_rr_arbiter #(.BIN_W(BIN_W), .LOCK(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .grant(g0), .grant_valid(v0)
  );

  versat_rr_arbiter #(.BIN_W(BIN_W), .LOCK(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .grant(g1), .grant_valid(v1)
  );

  function automatic int search(int ptr, logic [N:1] r);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = ((ptr - 1 + k) % N) + 1;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [N:1] oh(int g);
    logic [N:1] v;
    v = '0;
    if (g != 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(int m, logic r, logic e, logic [N:1] q);
    int w;
    if (r) begin
      m_g[m]   = 0;
      m_ptr[m] = N;
    end else if (!e) begin
      m_g[m] = 0;
    end else if (m == 1 && m_g[m] != 0 && q[m_g[m]]) begin
      m_g[m] = m_g[m];
    end else begin
      w = search(m_ptr[m], q);
      m_g[m] = w;
      if (w != 0) m_ptr[m] = w;
    end
  endtask

  task automatic step(logic r, logic e, logic [N:1] q);
    rst = r; en = e; req = q;
    @(posedge clk);
    model(0, r, e, q);
    model(1, r, e, q);
    #1;
    chk("u0_grant", 32'(g0), 32'(oh(m_g[0])));
    chk("u0_valid", 32'(v0), 32'(m_g[0] != 0));
    chk("u0_onehot0", 32'($onehot0(g0)), 32'd1);
    chk("u0_reqcons", 32'(g0 & ~q), 32'd0);
    chk("u1_grant", 32'(g1), 32'(oh(m_g[1])));
    chk("u1_valid", 32'(v1), 32'(m_g[1] != 0));
    chk("u1_onehot0", 32'($onehot0(g1)), 32'd1);
    chk("u1_reqcons", 32'(g1 & ~q), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req = '0;
    m_ptr[0] = N; m_ptr[1] = N;
    m_g[0] = 0;   m_g[1] = 0;

    // reset release
    step(1'b1, 1'b1, 3'b111);
    step(1'b1, 1'b1, 3'b111);
    chk("t1_rst_grant", 32'(g1), 32'b000);
    chk("t1_rst_valid", 32'(v1), 32'd0);
    step(1'b0, 1'b1, 3'b111);
    chk("t1_rel_u1", 32'(g1), 32'b001);
    chk("t1_rel_valid", 32'(v1), 32'd1);
    chk("t3_rot0", 32'(g0), 32'b001);

    // LOCK=1 hold and LOCK=0 rotation together
    step(1'b0, 1'b1, 3'b111);
    chk("t2_hold", 32'(g1), 32'b001);
    chk("t3_rot1", 32'(g0), 32'b010);
    step(1'b0, 1'b1, 3'b111);
    chk("t2_hold", 32'(g1), 32'b001);
    chk("t3_rot2", 32'(g0), 32'b100);
    step(1'b0, 1'b1, 3'b111);
    chk("t2_hold", 32'(g1), 32'b001);
    chk("t3_rot3", 32'(g0), 32'b001);
    step(1'b0, 1'b1, 3'b111);
    chk("t2_hold", 32'(g1), 32'b001);
    chk("t3_rot4", 32'(g0), 32'b010);
    step(1'b0, 1'b1, 3'b111);
    chk("t2_hold", 32'(g1), 32'b001);
    chk("t3_rot5", 32'(g0), 32'b100);

    // handoff
    step(1'b0, 1'b1, 3'b110);
    chk("t2_hand2", 32'(g1), 32'b010);
    step(1'b0, 1'b1, 3'b100);
    chk("t2_hand3", 32'(g1), 32'b100);
    step(1'b0, 1'b1, 3'b000);
    chk("t2_idle", 32'(g1), 32'b000);
    chk("t2_idle_v", 32'(v1), 32'd0);

    // wrap-around
    step(1'b0, 1'b1, 3'b010);
    chk("t4_ptr2", 32'(g1), 32'b010);
    step(1'b0, 1'b1, 3'b101);
    chk("t4_wrap3", 32'(g1), 32'b100);
    step(1'b0, 1'b1, 3'b001);
    chk("t4_wrap1", 32'(g1), 32'b001);

    // enable gating
    step(1'b0, 1'b1, 3'b010);
    chk("t5_g2", 32'(g1), 32'b010);
    step(1'b0, 1'b1, 3'b111);
    chk("t5_hold2", 32'(g1), 32'b010);
    step(1'b0, 1'b0, 3'b111);
    chk("t5_en_off", 32'(g1), 32'b000);
    chk("t5_en_off0", 32'(g0), 32'b000);
    step(1'b0, 1'b1, 3'b111);
    chk("t5_resume", 32'(g1), 32'b100);

    // reset mid-grant
    step(1'b1, 1'b1, 3'b111);
    chk("t6_rst", 32'(g1), 32'b000);
    step(1'b0, 1'b1, 3'b111);
    chk("t6_after", 32'(g1), 32'b001);

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 7) != 0),
           3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
